// File: rtl/display_timing_signed.sv
// display_timing_signed
//   Pixel-clock display timing generator with signed screen coordinates.
//   Coordinates are negative during blanking and reach (0,0) on the first
//   active pixel. All flags are registered from the next counter state, so
//   they describe the sx/sy present in the same cycle. A PIPE_DLY-stage
//   delay line re-times hsync/vsync/de for downstream pipeline latency.
//
// Ports
//   video_clk_pix  in   pixel clock
//   video_rst_n    in   asynchronous active-low reset
//   sx, sy         out  signed horizontal / vertical position (CORDW)
//   hsync, vsync   out  syncs at H_POL / V_POL polarity
//   de             out  data enable (sx >= 0 and sy >= 0)
//   frame_start    out  one-cycle strobe at (H_STA, V_STA)
//   line_start     out  one-cycle strobe at sx == H_STA
//   hsync_dly, vsync_dly, de_dly  out  delayed by PIPE_DLY cycles
//   frame_cnt      out  completed-frame counter (FRAMEW, wraps)
module display_timing_signed #(
  parameter int CORDW    = 16,
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 1,
  parameter int FRAMEW   = 16
) (
  input  logic                    video_clk_pix,
  input  logic                    video_rst_n,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame_start,
  output logic                    line_start,
  output logic                    hsync_dly,
  output logic                    vsync_dly,
  output logic                    de_dly,
  output logic [FRAMEW-1:0]       frame_cnt
);

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP - 1);
  localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP - 1);
  localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

  logic signed [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                    hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic                    ls_q, ls_d, fs_q, fs_d;
  logic [FRAMEW-1:0]       fcnt_q, fcnt_d;

  always_comb begin
    sx_d = sx_q + ONE;
    sy_d = sy_q;
    if (sx_q == HA_END) begin
      sx_d = H_STA;
      sy_d = (sy_q == VA_END) ? V_STA : sy_q + ONE;
    end
    // Flags are evaluated on the next state so they line up with sx/sy.
    hs_d   = ((sx_d >= HS_STA) && (sx_d <= HS_END)) ? H_POL : ~H_POL;
    vs_d   = ((sy_d >= VS_STA) && (sy_d <= VS_END)) ? V_POL : ~V_POL;
    de_d   = !sx_d[CORDW-1] && !sy_d[CORDW-1];
    ls_d   = (sx_d == H_STA);
    fs_d   = ls_d && (sy_d == V_STA);
    fcnt_d = fs_d ? fcnt_q + FRAMEW'(1) : fcnt_q;
  end

  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx_q   <= H_STA;
      sy_q   <= V_STA;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      de_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hsync_dly = hs_q;
      assign vsync_dly = vs_q;
      assign de_dly    = de_q;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

      always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
          hs_pipe_q <= {PIPE_DLY{~H_POL}};
          vs_pipe_q <= {PIPE_DLY{~V_POL}};
          de_pipe_q <= '0;
        end else begin
          hs_pipe_q[0] <= hs_q;
          vs_pipe_q[0] <= vs_q;
          de_pipe_q[0] <= de_q;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
            de_pipe_q[i] <= de_pipe_q[i-1];
          end
        end
      end

      assign hsync_dly = hs_pipe_q[PIPE_DLY-1];
      assign vsync_dly = vs_pipe_q[PIPE_DLY-1];
      assign de_dly    = de_pipe_q[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_display_timing_signed.sv
// Testbench for display_timing_signed using a small 8x4 raster with 1/1/1
// porches (H_TOTAL=11, V_TOTAL=7, frame=77 cycles).
// dut0: H_POL=V_POL=1, PIPE_DLY=3.  dut1: H_POL=V_POL=0, PIPE_DLY=0.
// Both use FRAMEW=2.
module tb_display_timing_signed;

  localparam int HT = 11;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic clk, rst_n;

  logic signed [15:0] sx0, sy0, sx1, sy1;
  logic hs0, vs0, de0, fs0, ls0, hsd0, vsd0, ded0;
  logic hs1, vs1, de1, fs1, ls1, hsd1, vsd1, ded1;
  logic [1:0] fc0, fc1;

  display_timing_signed #(
    .CORDW(16), .H_RES(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(3), .FRAMEW(2)
  ) dut0 (
    .video_clk_pix(clk), .video_rst_n(rst_n),
    .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0), .de(de0),
    .frame_start(fs0), .line_start(ls0),
    .hsync_dly(hsd0), .vsync_dly(vsd0), .de_dly(ded0), .frame_cnt(fc0)
  );

  display_timing_signed #(
    .CORDW(16), .H_RES(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(0), .FRAMEW(2)
  ) dut1 (
    .video_clk_pix(clk), .video_rst_n(rst_n),
    .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1), .de(de1),
    .frame_start(fs1), .line_start(ls1),
    .hsync_dly(hsd1), .vsync_dly(vsd1), .de_dly(ded1), .frame_cnt(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset: the position index of the raster.
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  typedef struct {
    int k;
    int sx, sy, fc;
    bit hs, vs, de, ls, fs;      // active-high polarity (dut0)
    bit hsd, vsd, ded;           // dut0 delayed by 3
  } exp_t;

  typedef struct {
    int k, sx, sy, de, ls, fs, fc;
  } vec_t;

  exp_t exp_q[$];
  bit   hs_hist[0:1023], vs_hist[0:1023], de_hist[0:1023];

  int n_cmp = 0;
  int n_bad = 0;
  bit driving = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %0d, expected %0d", name, k, act, req);
    end
  endtask

  function automatic exp_t model(input int kk);
    exp_t e;
    int idx;
    idx   = kk % FT;
    e.k   = kk;
    e.sx  = -3 + idx % HT;
    e.sy  = -3 + idx / HT;
    e.hs  = (e.sx == -2);
    e.vs  = (e.sy == -2);
    e.de  = (e.sx >= 0) && (e.sy >= 0);
    e.ls  = (kk > 0) && (idx % HT == 0);
    e.fs  = (kk > 0) && (idx == 0);
    e.fc  = (kk / FT) % 4;
    e.hsd = 1'b0;
    e.vsd = 1'b0;
    e.ded = 1'b0;
    return e;
  endfunction

  // Hand-computed points on the small raster.
  vec_t vecs[12] = '{
    '{0,   -3, -3, 0, 0, 0, 0},
    '{1,   -2, -3, 0, 0, 0, 0},
    '{10,   7, -3, 0, 0, 0, 0},
    '{11,  -3, -2, 0, 1, 0, 0},
    '{35,  -1,  0, 0, 0, 0, 0},
    '{36,   0,  0, 1, 0, 0, 0},
    '{76,   7,  3, 1, 0, 0, 0},
    '{77,  -3, -3, 0, 1, 1, 1},
    '{154, -3, -3, 0, 1, 1, 2},
    '{231, -3, -3, 0, 1, 1, 3},
    '{308, -3, -3, 0, 1, 1, 0},
    '{385, -3, -3, 0, 1, 1, 1}
  };

  // Driver: applies reset stimulus and pushes the expected response.
  initial begin
    exp_t e;
    rst_n = 1'b0;
    for (int cyc = 0; cyc < 520; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3)   rst_n = 1'b1;
      if (cyc == 405) rst_n = 1'b0;   // mid-line, mid-frame async reset
      if (cyc == 410) rst_n = 1'b1;
      #1;
      e = model(k);
      hs_hist[k & 1023] = e.hs;
      vs_hist[k & 1023] = e.vs;
      de_hist[k & 1023] = e.de;
      if (k >= 3) begin
        e.hsd = hs_hist[(k - 3) & 1023];
        e.vsd = vs_hist[(k - 3) & 1023];
        e.ded = de_hist[(k - 3) & 1023];
      end
      exp_q.push_back(e);
    end
    driving = 1'b0;
  end

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  int de_cnt = 0;
  bit de_done = 1'b0;
  initial begin
    exp_t e;
    while (driving || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sx0", int'(sx0), e.sx);
        chk("sy0", int'(sy0), e.sy);
        chk("hsync0", int'(hs0), int'(e.hs));
        chk("vsync0", int'(vs0), int'(e.vs));
        chk("de0", int'(de0), int'(e.de));
        chk("line_start0", int'(ls0), int'(e.ls));
        chk("frame_start0", int'(fs0), int'(e.fs));
        chk("frame_cnt0", int'(fc0), e.fc);
        chk("hsync_dly0", int'(hsd0), int'(e.hsd));
        chk("vsync_dly0", int'(vsd0), int'(e.vsd));
        chk("de_dly0", int'(ded0), int'(e.ded));
        chk("sx1", int'(sx1), e.sx);
        chk("sy1", int'(sy1), e.sy);
        chk("hsync1", int'(hs1), int'(!e.hs));
        chk("vsync1", int'(vs1), int'(!e.vs));
        chk("de1", int'(de1), int'(e.de));
        chk("line_start1", int'(ls1), int'(e.ls));
        chk("frame_start1", int'(fs1), int'(e.fs));
        chk("frame_cnt1", int'(fc1), e.fc);
        chk("hsync_dly1", int'(hsd1), int'(!e.hs));
        chk("vsync_dly1", int'(vsd1), int'(!e.vs));
        chk("de_dly1", int'(ded1), int'(e.de));
        foreach (vecs[i]) begin
          if (vecs[i].k == e.k) begin
            chk("vec_sx", int'(sx0), vecs[i].sx);
            chk("vec_sy", int'(sy0), vecs[i].sy);
            chk("vec_de", int'(de0), vecs[i].de);
            chk("vec_ls", int'(ls0), vecs[i].ls);
            chk("vec_fs", int'(fs0), vecs[i].fs);
            chk("vec_fc", int'(fc0), vecs[i].fc);
          end
        end
        if (!de_done && e.k >= FT && e.k < 2 * FT) de_cnt += int'(de0);
        if (!de_done && e.k == 2 * FT) begin
          de_done = 1'b1;
          chk("de_per_frame", de_cnt, 32);
        end
      end
    end
    if (!de_done) chk("de_per_frame_reached", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
